dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Data-side responder for the MEM stage memory port.
- Direct-mapped, write-back, write-allocate data cache.
- Accepts word-aligned read and write requests with byte enables and returns `mem_rdata` plus `mem_resp`.
- Misses are serviced over a 256-bit line interface to physical memory (`pmem_*`), including dirty-victim writeback.

Parameters:
- S_OFFSET, 5, log2 of line size in bytes (32-byte, 256-bit lines)
- S_INDEX, 3, log2 of set count (8 sets)
- S_TAG, 32-S_OFFSET-S_INDEX, tag width (derived; not overridable)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- mem_address  input  32  CPU request address; bits [1:0] are always 0
- mem_wdata  input  32  write data, already lane-aligned by the requester
- mem_byte_enable  input  4  byte lanes written on a store
- data_read  input  1  read request; held until mem_resp
- data_write  input  1  write request; held until mem_resp
- mem_rdata  output  32  word at mem_address[4:2] of the indexed line
- mem_resp  output  1  one-cycle completion pulse
- pmem_address  output  32  line address, bits [4:0] = 0
- pmem_wdata  output  256  victim line for writeback
- pmem_rdata  input  256  fill line
- pmem_read  output  1  line read request; held until pmem_resp
- pmem_write  output  1  line write request; held until pmem_resp
- pmem_resp  input  1  line transfer complete

Behaviour:
- Address split: tag = [31:8], index = [7:5], word = [4:2].
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - mem_resp = 0, pmem_read = 0, pmem_write = 0.
  - All valid and dirty bits cleared.
  - Tag and data arrays are not reset.
  - A reset during WB or FILL abandons the transfer immediately; the line in flight is discarded.
- States:
  - IDLE:
    - If data_read or data_write, go to CHECK. Otherwise stay.
    - mem_resp = 0.
  - CHECK:
    - hit = valid[index] and (tag_array[index] == tag).
    - Hit, read: mem_resp = 1 this cycle, mem_rdata valid; go to IDLE.
    - Hit, write: mem_resp = 1. At the clock edge, byte lanes with mem_byte_enable[i] = 1 are merged into word[word]. dirty set only if byte_enable != 0. Go to IDLE.
    - Miss, victim valid and dirty: go to WB.
    - Miss otherwise: go to FILL.
    - No request present (requester dropped it): no resp; go to IDLE.
  - WB:
    - pmem_write = 1.
    - pmem_address = {tag_array[index], index, 5'b0}.
    - pmem_wdata = data_array[index].
    - On pmem_resp: clear dirty, go to FILL.
  - FILL:
    - pmem_read = 1.
    - pmem_address = {tag, index, 5'b0}.
    - On pmem_resp: write pmem_rdata into the line, store the tag, valid = 1, dirty = 0, go to CHECK (the retried access hits).
- Latency:
  - Hit: mem_resp in the 2nd cycle of the request.
  - Clean miss: 2 + fill cycles + 1.
  - Dirty miss: adds writeback cycles.
- mem_resp is high for exactly one cycle per request. After IDLE, a request still asserted is treated as a new request.
- data_read and data_write both high is illegal; it is treated as a write.
- pmem_read and pmem_write are never both high. Both are Moore outputs of the state.
- Outside CHECK-hit cycles, mem_rdata is combinational from the arrays and meaningless.

Decomposition:
- Package dcache_types:
  - S_OFFSET, S_INDEX, S_TAG constants
  - dcache_state_t enum {IDLE, CHECK, WB, FILL}
  - dcache_line_t (logic [255:0])
- Sub-module dcache_array:
  - Holds data, tag, valid and dirty arrays.
  - Async-low reset on valid and dirty only.
  - Provides a byte-enabled word write port and a full-line write port.
- dcache_responder holds the FSM, hit compare and muxing.

Test Plan:
- Cold read 0x0000_0104, memory line 0x100 = word k holds 0x1111_0000+k:
  - FILL with pmem_address 0x100, then mem_resp with mem_rdata 0x1111_0001.
  - A repeat read is a hit with resp in cycle 2.
- Write hit 0x104, wdata 0xAABB_CCDD, be 4'b0110, prior 0x1111_0001:
  - Read back 0x11BB_CC01.
  - dirty[0] = 1.
  - No pmem activity.
- Conflict read 0x0000_0204 after the dirty write above:
  - WB at pmem_address 0x100 with word1 = 0x11BB_CC01.
  - Then FILL at 0x200.
  - Then mem_resp.
  - pmem_read and pmem_write are never simultaneous.
- Write with be 4'b0000 to a cached clean line:
  - mem_resp = 1.
  - Data unchanged, dirty stays 0.
- Reset pulse (rst=0 for 1 cycle) mid-FILL with pmem_resp pending:
  - pmem_read drops asynchronously.
  - State IDLE.
  - A subsequent read of the same address misses again.
- Requester drops data_read during FILL:
  - Fill completes and the line is valid.
  - CHECK sees no request, so no mem_resp; return to IDLE.

Source files
------------

// File: rtl/dcache_types_pkg.sv
// dcache_types: shared constants and types for the data-cache responder.
//   S_OFFSET / S_INDEX / S_TAG : address split (byte offset, set index, tag).
//   NUM_SETS, LINE_W           : derived array geometry.
//   dcache_state_t             : controller states.
//   dcache_line_t              : one 256-bit cache line.
`timescale 1ns/1ps
package dcache_types;
  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_SETS = 1 << S_INDEX;
  localparam int LINE_W   = 8 << S_OFFSET;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WB    = 2'd2,
    FILL  = 2'd3
  } dcache_state_t;

  typedef logic [255:0] dcache_line_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: storage for the direct-mapped data cache.
//   clk, rst       : clock; async active-low reset (valid/dirty only).
//   index          : set selected for both reads and writes.
//   word_sel, word_wdata, word_be, word_we : byte-enabled word store port.
//   line_wdata, line_tag, line_we          : full-line fill port (sets valid, clears dirty).
//   clr_dirty      : clears dirty after a victim writeback.
//   rd_line, rd_tag, rd_valid, rd_dirty    : combinational view of the indexed set.
`timescale 1ns/1ps
module dcache_array
  import dcache_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] index,
  input  logic [2:0]         word_sel,
  input  logic [31:0]        word_wdata,
  input  logic [3:0]         word_be,
  input  logic               word_we,
  input  dcache_line_t       line_wdata,
  input  logic [S_TAG-1:0]   line_tag,
  input  logic               line_we,
  input  logic               clr_dirty,
  output dcache_line_t       rd_line,
  output logic [S_TAG-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty
);

  dcache_line_t       data_array [NUM_SETS];
  logic [S_TAG-1:0]   tag_array  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_bits;
  logic [NUM_SETS-1:0] dirty_bits;

  // Data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_array[index] <= line_wdata;
      tag_array[index]  <= line_tag;
    end else if (word_we) begin
      for (int i = 0; i < 4; i++) begin
        if (word_be[i])
          data_array[index][{word_sel, i[1:0], 3'b000} +: 8] <= word_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else begin
      if (line_we) begin
        valid_bits[index] <= 1'b1;
        dirty_bits[index] <= 1'b0;
      end else if (word_we && (|word_be)) begin
        // An all-zero byte enable changes nothing, so it must not dirty the line.
        dirty_bits[index] <= 1'b1;
      end else if (clr_dirty) begin
        dirty_bits[index] <= 1'b0;
      end
    end
  end

  assign rd_line  = data_array[index];
  assign rd_tag   = tag_array[index];
  assign rd_valid = valid_bits[index];
  assign rd_dirty = dirty_bits[index];

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, write-allocate data cache.
//   clk, rst                    : clock; async active-low reset.
//   mem_address, mem_wdata, mem_byte_enable, data_read, data_write : CPU request.
//   mem_rdata, mem_resp         : CPU response (mem_resp is a one-cycle pulse).
//   pmem_address, pmem_wdata, pmem_read, pmem_write : 256-bit line port to memory.
//   pmem_rdata, pmem_resp       : line fill data and transfer-complete strobe.
`timescale 1ns/1ps
module dcache_responder
  import dcache_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  input  logic         data_read,
  input  logic         data_write,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp
);

  dcache_state_t      state, state_next;
  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_index;
  logic [2:0]         req_word;
  logic               req;
  logic               hit;
  dcache_line_t       rd_line;
  logic [S_TAG-1:0]   rd_tag;
  logic               rd_valid, rd_dirty;
  logic               word_we, line_we, clr_dirty;
  logic               unused_addr_lsb;

  assign req_tag         = mem_address[31:8];
  assign req_index       = mem_address[7:5];
  assign req_word        = mem_address[4:2];
  assign unused_addr_lsb = ^mem_address[1:0];

  // A write dominates if both request lines are raised.
  assign req = data_read | data_write;
  assign hit = rd_valid && (rd_tag == req_tag);

  dcache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (req_index),
    .word_sel   (req_word),
    .word_wdata (mem_wdata),
    .word_be    (mem_byte_enable),
    .word_we    (word_we),
    .line_wdata (pmem_rdata),
    .line_tag   (req_tag),
    .line_we    (line_we),
    .clr_dirty  (clr_dirty),
    .rd_line    (rd_line),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty)
  );

  assign mem_rdata  = rd_line[{req_word, 5'b00000} +: 32];
  assign pmem_wdata = rd_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req) state_next = CHECK;
      CHECK: begin
        if (!req)                     state_next = IDLE;
        else if (hit)                 state_next = IDLE;
        else if (rd_valid && rd_dirty) state_next = WB;
        else                          state_next = FILL;
      end
      WB:    if (pmem_resp) state_next = FILL;
      FILL:  if (pmem_resp) state_next = CHECK;
      default: state_next = IDLE;
    endcase
  end

  // pmem_read/pmem_write depend on state alone, so an async reset drops them at once.
  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    word_we      = 1'b0;
    line_we      = 1'b0;
    clr_dirty    = 1'b0;
    pmem_address = {req_tag, req_index, 5'b00000};
    case (state)
      CHECK: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          word_we  = data_write;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {rd_tag, req_index, 5'b00000};
        clr_dirty    = pmem_resp;
      end
      FILL: begin
        pmem_read = 1'b1;
        line_we   = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_responder.sv
`timescale 1ns/1ps
module tb_dcache_responder;
  import dcache_types::*;

  localparam int PM_LAT  = 3;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic         data_read;
  logic         data_write;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .data_read       (data_read),
    .data_write      (data_write),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_resp       (pmem_resp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory (32 lines) and a word-level golden model of the CPU view.
  logic [255:0] pmem [32];
  logic [31:0]  ref_mem [256];
  logic [31:0]  ev_addr [$];
  bit           ev_wr [$];
  logic [255:0] last_wb;
  bit           pmem_hold = 1'b0;
  bit           overlap   = 1'b0;
  int           lat_cnt   = 0;

  function automatic logic [31:0] line_word(input int n, input int k);
    if (n % 8 == 0 && n != 0) return (n / 8) * 32'h1111_0000 + k;
    return {8'hA0, n[7:0], k[15:0]};
  endfunction

  initial begin
    for (int n = 0; n < 32; n++)
      for (int k = 0; k < 8; k++) begin
        pmem[n][k*32 +: 32] = line_word(n, k);
        ref_mem[n*8 + k]    = line_word(n, k);
      end
  end

  // Line-memory responder: PM_LAT cycles of request before a one-cycle resp.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) overlap = 1'b1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        lat_cnt   = 0;
      end
      if (!pmem_hold && (pmem_read || pmem_write)) begin
        lat_cnt++;
        if (lat_cnt >= PM_LAT) begin
          if (pmem_write) begin
            pmem[pmem_address[9:5]] = pmem_wdata;
            last_wb = pmem_wdata;
            ev_wr.push_back(1'b1);
          end else begin
            pmem_rdata = pmem[pmem_address[9:5]];
            ev_wr.push_back(1'b0);
          end
          ev_addr.push_back(pmem_address);
          pmem_resp = 1'b1;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q [$];

  // One CPU access; lat counts the request cycle as 1.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int lat);
    sb_t e;
    bit  got;
    e.is_wr = wr;
    e.exp   = wr ? 32'h0 : ref_mem[addr[9:2]];
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[addr[9:2]][i*8 +: 8] = wdata[i*8 +: 8];
    sb_q.push_back(e);
    @(negedge clk);
    mem_address     = addr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
    data_read       = !wr;
    data_write      = wr;
    lat = 1;
    got = 1'b0;
    while (!got && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_resp) got = 1'b1;
    end
    if (!got) begin
      check_eq($sformatf("resp_timeout_%08h", addr), 32'(mem_resp), 32'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      if (!e.is_wr) check_eq($sformatf("rdata_%08h", addr), mem_rdata, e.exp);
    end
    // Hold through the edge that commits a store, then release.
    @(posedge clk);
    #1;
    data_read  = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic wait_pmem_read(input string tag);
    int n = 0;
    while (!pmem_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(pmem_read), 32'd1);
  endtask

  int lat;
  int ev0;
  bit resp_seen;

  initial begin
    rst = 1'b0;
    mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    data_read = 1'b0; data_write = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_resp", 32'(mem_resp), 32'd0);
    check_eq("rst_pmem_read", 32'(pmem_read), 32'd0);
    check_eq("rst_pmem_write", 32'(pmem_write), 32'd0);
    rst = 1'b1;

    // Cold read fills line 0x100.
    ev0 = ev_addr.size();
    access(1'b0, 32'h0000_0104, '0, 4'h0, lat);
    check_eq("cold_lat", lat, 6);
    check_eq("cold_ev_cnt", ev_addr.size() - ev0, 1);
    if (ev_addr.size() > ev0) begin
      check_eq("cold_fill_addr", ev_addr[ev0], 32'h0000_0100);
      check_eq("cold_fill_rd", 32'(ev_wr[ev0]), 32'd0);
    end

    // Repeat read hits.
    ev0 = ev_addr.size();
    access(1'b0, 32'h0000_0104, '0, 4'h0, lat);
    check_eq("hit_lat", lat, 2);

    // Write hit with partial byte enables, then read it back.
    access(1'b1, 32'h0000_0104, 32'hAABB_CCDD, 4'b0110, lat);
    check_eq("wr_hit_lat", lat, 2);
    check_eq("wr_dirty0", 32'(dut.u_array.dirty_bits[0]), 32'd1);
    access(1'b0, 32'h0000_0104, '0, 4'h0, lat);
    check_eq("wr_readback_const", mem_rdata, 32'h11BB_CC01);
    check_eq("wr_no_pmem", ev_addr.size() - ev0, 0);

    // Conflict read evicts the dirty line.
    ev0 = ev_addr.size();
    access(1'b0, 32'h0000_0204, '0, 4'h0, lat);
    check_eq("dirty_lat", lat, 9);
    check_eq("dirty_ev_cnt", ev_addr.size() - ev0, 2);
    if (ev_addr.size() >= ev0 + 2) begin
      check_eq("wb_is_write", 32'(ev_wr[ev0]), 32'd1);
      check_eq("wb_addr", ev_addr[ev0], 32'h0000_0100);
      check_eq("wb_word1", last_wb[63:32], 32'h11BB_CC01);
      check_eq("fill_is_read", 32'(ev_wr[ev0+1]), 32'd0);
      check_eq("fill_addr", ev_addr[ev0+1], 32'h0000_0200);
    end

    // Zero byte-enable store to a clean line.
    ev0 = ev_addr.size();
    access(1'b1, 32'h0000_0208, 32'hDEAD_BEEF, 4'b0000, lat);
    check_eq("be0_lat", lat, 2);
    check_eq("be0_dirty", 32'(dut.u_array.dirty_bits[0]), 32'd0);
    access(1'b0, 32'h0000_0208, '0, 4'h0, lat);
    check_eq("be0_readback_const", mem_rdata, 32'h2222_0002);
    check_eq("be0_no_pmem", ev_addr.size() - ev0, 0);

    // Reset pulse while a fill is outstanding.
    pmem_hold = 1'b1;
    @(negedge clk);
    mem_address = 32'h0000_0044;
    data_read   = 1'b1;
    wait_pmem_read("rstfill_pmem_read_up");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rstfill_pmem_read_drop", 32'(pmem_read), 32'd0);
    check_eq("rstfill_state", 32'(dut.state), 32'(IDLE));
    data_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pmem_hold = 1'b0;
    ev0 = ev_addr.size();
    access(1'b0, 32'h0000_0044, '0, 4'h0, lat);
    check_eq("rstfill_remiss_lat", lat, 6);
    check_eq("rstfill_remiss_ev", ev_addr.size() - ev0, 1);

    // Requester abandons its read during the fill.
    pmem_hold = 1'b1;
    @(negedge clk);
    mem_address = 32'h0000_0068;
    data_read   = 1'b1;
    wait_pmem_read("drop_pmem_read_up");
    ev0 = ev_addr.size();
    data_read = 1'b0;
    pmem_hold = 1'b0;
    resp_seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (mem_resp) resp_seen = 1'b1;
    end
    check_eq("drop_no_resp", 32'(resp_seen), 32'd0);
    check_eq("drop_fill_done", ev_addr.size() - ev0, 1);
    check_eq("drop_state", 32'(dut.state), 32'(IDLE));
    ev0 = ev_addr.size();
    access(1'b0, 32'h0000_0068, '0, 4'h0, lat);
    check_eq("drop_hit_lat", lat, 2);
    check_eq("drop_hit_no_pmem", ev_addr.size() - ev0, 0);

    check_eq("pmem_exclusive", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
